// File: rtl/ex_pipeline_sequencer_if.sv
// Bundles the pipeline-control inputs and stage enable/flush outputs of the
// execution-stage sequencer. The master side is the pipeline/debug unit.
interface ex_pipeline_sequencer_if #(
    parameter int CNT_WIDTH = 32
);
    logic                 i_start;
    logic                 i_mode;
    logic                 i_step;
    logic                 i_clear;
    logic [4:0]           i_id_rs_addr;
    logic [4:0]           i_id_rt_addr;
    logic                 i_id_uses_rt;
    logic [4:0]           i_ex_rt_addr;
    logic                 i_ex_mem_read;
    logic                 i_ex_taken;
    logic                 i_ex_halt;
    logic                 o_pc_en;
    logic                 o_if_id_en;
    logic                 o_if_id_flush;
    logic                 o_id_ex_en;
    logic                 o_id_ex_flush;
    logic                 o_ex_mem_en;
    logic                 o_mem_wb_en;
    logic                 o_halted;
    logic [2:0]           o_state;
    logic [CNT_WIDTH-1:0] o_cycle_cnt;
    logic [CNT_WIDTH-1:0] o_stall_cnt;

    modport master (
        output i_start, i_mode, i_step, i_clear,
        output i_id_rs_addr, i_id_rt_addr, i_id_uses_rt,
        output i_ex_rt_addr, i_ex_mem_read, i_ex_taken, i_ex_halt,
        input  o_pc_en, o_if_id_en, o_if_id_flush, o_id_ex_en, o_id_ex_flush,
        input  o_ex_mem_en, o_mem_wb_en, o_halted, o_state,
        input  o_cycle_cnt, o_stall_cnt
    );

    modport slave (
        input  i_start, i_mode, i_step, i_clear,
        input  i_id_rs_addr, i_id_rt_addr, i_id_uses_rt,
        input  i_ex_rt_addr, i_ex_mem_read, i_ex_taken, i_ex_halt,
        output o_pc_en, o_if_id_en, o_if_id_flush, o_id_ex_en, o_id_ex_flush,
        output o_ex_mem_en, o_mem_wb_en, o_halted, o_state,
        output o_cycle_cnt, o_stall_cnt
    );
endinterface

// File: rtl/ex_pipeline_sequencer.sv
// Stall/flush/step controller for the 5-stage pipeline: run/step sequencing,
// load-use bubbles, taken-branch squash and HALT drain with debug counters.
module ex_pipeline_sequencer #(
    parameter int DRAIN_CYCLES = 2,
    parameter int CNT_WIDTH    = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    ex_pipeline_sequencer_if.slave   bus
);
    localparam int DW = $clog2(DRAIN_CYCLES + 2);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_RUN    = 3'd1,
        S_STEP   = 3'd2,
        S_DRAIN  = 3'd3,
        S_HALTED = 3'd4
    } state_t;

    state_t               r_state;
    logic [DW-1:0]        r_drain;
    logic                 r_step_prev;
    logic                 r_halted;
    logic [CNT_WIDTH-1:0] r_cycle_cnt;
    logic [CNT_WIDTH-1:0] r_stall_cnt;

    logic w_adv;
    logic w_exec;
    logic w_load_use;
    logic w_halt_take;
    logic w_stall;
    logic w_pc_en;
    logic w_if_id_en;
    logic w_if_id_flush;
    logic w_id_ex_en;
    logic w_id_ex_flush;
    logic w_ex_mem_en;
    logic w_mem_wb_en;

    assign w_load_use = bus.i_ex_mem_read && (bus.i_ex_rt_addr != 5'd0) &&
                        ((bus.i_ex_rt_addr == bus.i_id_rs_addr) ||
                         (bus.i_id_uses_rt && (bus.i_ex_rt_addr == bus.i_id_rt_addr)));

    always_comb begin
        w_adv = 1'b0;
        case (r_state)
            S_RUN:   w_adv = 1'b1;
            S_STEP:  w_adv = bus.i_step && !r_step_prev;
            S_DRAIN: w_adv = 1'b1;
            default: w_adv = 1'b0;
        endcase
    end

    assign w_exec      = w_adv && ((r_state == S_RUN) || (r_state == S_STEP));
    assign w_halt_take = w_exec && bus.i_ex_halt;
    assign w_stall     = w_exec && !bus.i_ex_halt && !bus.i_ex_taken && w_load_use;

    // Halt and drain share the stall pattern: front end frozen, bubble into EX.
    always_comb begin
        w_pc_en       = 1'b0;
        w_if_id_en    = 1'b0;
        w_if_id_flush = 1'b0;
        w_id_ex_en    = 1'b0;
        w_id_ex_flush = 1'b0;
        w_ex_mem_en   = 1'b0;
        w_mem_wb_en   = 1'b0;
        if (w_adv) begin
            w_id_ex_en  = 1'b1;
            w_ex_mem_en = 1'b1;
            w_mem_wb_en = 1'b1;
            if ((r_state == S_DRAIN) || bus.i_ex_halt || w_load_use) begin
                if ((r_state != S_DRAIN) && !bus.i_ex_halt && bus.i_ex_taken) begin
                    w_pc_en       = 1'b1;
                    w_if_id_en    = 1'b1;
                    w_if_id_flush = 1'b1;
                end
                w_id_ex_flush = 1'b1;
            end else begin
                w_pc_en       = 1'b1;
                w_if_id_en    = 1'b1;
                w_if_id_flush = bus.i_ex_taken;
                w_id_ex_flush = bus.i_ex_taken;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_drain     <= '0;
            r_step_prev <= 1'b0;
            r_halted    <= 1'b0;
            r_cycle_cnt <= '0;
            r_stall_cnt <= '0;
        end else begin
            r_step_prev <= bus.i_step;
            if (w_adv) begin
                r_cycle_cnt <= r_cycle_cnt + CNT_WIDTH'(1);
            end
            if (w_stall) begin
                r_stall_cnt <= r_stall_cnt + CNT_WIDTH'(1);
            end
            case (r_state)
                S_IDLE: begin
                    if (bus.i_start) begin
                        r_state <= bus.i_mode ? S_STEP : S_RUN;
                    end
                end
                S_RUN, S_STEP: begin
                    if (w_halt_take) begin
                        r_drain <= DW'(DRAIN_CYCLES);
                        r_state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    r_drain <= r_drain - DW'(1);
                    if (r_drain <= DW'(1)) begin
                        r_state  <= S_HALTED;
                        r_halted <= 1'b1;
                    end
                end
                S_HALTED: begin
                    if (bus.i_clear) begin
                        r_state     <= S_IDLE;
                        r_halted    <= 1'b0;
                        r_cycle_cnt <= '0;
                        r_stall_cnt <= '0;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.o_pc_en       = w_pc_en;
    assign bus.o_if_id_en    = w_if_id_en;
    assign bus.o_if_id_flush = w_if_id_flush;
    assign bus.o_id_ex_en    = w_id_ex_en;
    assign bus.o_id_ex_flush = w_id_ex_flush;
    assign bus.o_ex_mem_en   = w_ex_mem_en;
    assign bus.o_mem_wb_en   = w_mem_wb_en;
    assign bus.o_halted      = r_halted;
    assign bus.o_state       = r_state;
    assign bus.o_cycle_cnt   = r_cycle_cnt;
    assign bus.o_stall_cnt   = r_stall_cnt;
endmodule

// File: tb/tb_ex_pipeline_sequencer.sv
// Directed and randomized checks of ex_pipeline_sequencer against a
// behavioural model of the run/step/drain rules.
module tb_ex_pipeline_sequencer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ex_pipeline_sequencer_if #(.CNT_WIDTH(32)) bus ();
    ex_pipeline_sequencer #(.DRAIN_CYCLES(2), .CNT_WIDTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int total = 0;
    int bad   = 0;

    // model state: 0 idle, 1 run, 2 step, 3 drain, 4 halted
    int          m_st;
    int          m_drain_left;
    bit          m_prev_step;
    bit          m_halted;
    bit [31:0]   m_cyc;
    bit [31:0]   m_stall;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clr_in();
        bus.i_start = 0; bus.i_mode = 0; bus.i_step = 0; bus.i_clear = 0;
        bus.i_id_rs_addr = 0; bus.i_id_rt_addr = 0; bus.i_id_uses_rt = 0;
        bus.i_ex_rt_addr = 0; bus.i_ex_mem_read = 0; bus.i_ex_taken = 0; bus.i_ex_halt = 0;
    endtask

    task automatic model_reset();
        m_st = 0; m_drain_left = 0; m_prev_step = 0; m_halted = 0; m_cyc = 0; m_stall = 0;
    endtask

    // One clock: check stage controls mid-cycle, then registered state after the edge.
    task automatic tick();
        bit adv, lu;
        logic [6:0] exp_en;
        logic [6:0] obs_en;
        @(negedge clk);
        adv = (m_st == 1) || (m_st == 2 && bus.i_step && !m_prev_step) || (m_st == 3);
        lu  = bus.i_ex_mem_read && bus.i_ex_rt_addr != 0 &&
              (bus.i_ex_rt_addr == bus.i_id_rs_addr ||
               (bus.i_id_uses_rt && bus.i_ex_rt_addr == bus.i_id_rt_addr));
        // order: pc, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem, mem_wb
        if (!adv)                          exp_en = 7'b000_0000;
        else if (m_st == 3 || bus.i_ex_halt) exp_en = 7'b000_1111;
        else if (bus.i_ex_taken)           exp_en = 7'b111_1111;
        else if (lu)                       exp_en = 7'b000_1111;
        else                               exp_en = 7'b110_1011;
        obs_en = {bus.o_pc_en, bus.o_if_id_en, bus.o_if_id_flush, bus.o_id_ex_en,
                  bus.o_id_ex_flush, bus.o_ex_mem_en, bus.o_mem_wb_en};
        check("enables", {25'd0, obs_en}, {25'd0, exp_en});
        @(posedge clk);
        if (rst) begin
            model_reset();
        end else begin
            if (adv) m_cyc++;
            if (adv && (m_st == 1 || m_st == 2) && !bus.i_ex_halt && !bus.i_ex_taken && lu) m_stall++;
            case (m_st)
                0: if (bus.i_start) m_st = bus.i_mode ? 2 : 1;
                1, 2: if (adv && bus.i_ex_halt) begin m_st = 3; m_drain_left = 2; end
                3: begin
                    if (m_drain_left <= 1) begin m_st = 4; m_halted = 1; end
                    else m_drain_left--;
                end
                4: if (bus.i_clear) begin m_st = 0; m_halted = 0; m_cyc = 0; m_stall = 0; end
                default: m_st = 0;
            endcase
            m_prev_step = bus.i_step;
        end
        #1;
        check("state",  {29'd0, bus.o_state}, m_st[31:0]);
        check("halted", {31'd0, bus.o_halted}, {31'd0, m_halted});
        check("cycle_cnt", bus.o_cycle_cnt, m_cyc);
        check("stall_cnt", bus.o_stall_cnt, m_stall);
    endtask

    initial begin
        clr_in();
        rst = 1;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        tick();
        check("reset_state", {29'd0, bus.o_state}, 32'd0);
        check("reset_cycle", bus.o_cycle_cnt, 32'd0);
        rst = 0;

        // continuous run, no hazards
        bus.i_start = 1; bus.i_mode = 0; tick(); bus.i_start = 0;
        repeat (5) tick();
        check("run_state", {29'd0, bus.o_state}, 32'd1);
        check("run_cycle5", bus.o_cycle_cnt, 32'd5);
        check("run_stall0", bus.o_stall_cnt, 32'd0);

        // load-use on rs, then same with r0 destination
        bus.i_ex_mem_read = 1; bus.i_ex_rt_addr = 5; bus.i_id_rs_addr = 5; tick();
        check("lu_stall1", bus.o_stall_cnt, 32'd1);
        bus.i_ex_rt_addr = 0; bus.i_id_rs_addr = 0; tick();
        check("lu_r0_nostall", bus.o_stall_cnt, 32'd1);

        // load-use on rt only counts when rt is a source
        bus.i_ex_rt_addr = 7; bus.i_id_rs_addr = 1; bus.i_id_rt_addr = 7; bus.i_id_uses_rt = 0; tick();
        check("lu_rt_unused", bus.o_stall_cnt, 32'd1);
        bus.i_id_uses_rt = 1; tick();
        check("lu_rt_used", bus.o_stall_cnt, 32'd2);

        // taken branch wins over load-use
        bus.i_ex_taken = 1; tick();
        check("taken_stall_same", bus.o_stall_cnt, 32'd2);
        clr_in();

        // halt together with taken -> drain 2 cycles -> halted
        bus.i_ex_halt = 1; bus.i_ex_taken = 1; tick(); clr_in();
        check("drain_state", {29'd0, bus.o_state}, 32'd3);
        bus.i_ex_taken = 1; bus.i_ex_mem_read = 1; bus.i_ex_rt_addr = 3; bus.i_id_rs_addr = 3;
        repeat (2) tick();
        clr_in();
        check("halted_state", {29'd0, bus.o_state}, 32'd4);
        check("halted_flag", {31'd0, bus.o_halted}, 32'd1);
        bus.i_start = 1; tick(); bus.i_start = 0;
        check("start_ignored", {29'd0, bus.o_state}, 32'd4);
        bus.i_clear = 1; tick(); bus.i_clear = 0;
        check("clear_idle", {29'd0, bus.o_state}, 32'd0);
        check("clear_cycle", bus.o_cycle_cnt, 32'd0);

        // step mode: held high gives one advance, then one pulse
        bus.i_start = 1; bus.i_mode = 1; tick(); clr_in();
        bus.i_step = 1; repeat (4) tick();
        bus.i_step = 0; tick();
        bus.i_step = 1; tick();
        bus.i_step = 0; repeat (2) tick();
        check("step_cycle2", bus.o_cycle_cnt, 32'd2);

        // reset in the middle of a drain
        rst = 1; tick(); rst = 0;
        bus.i_start = 1; bus.i_mode = 0; tick(); clr_in();
        bus.i_ex_halt = 1; tick(); clr_in();
        tick();
        rst = 1; tick(); rst = 0;
        check("rst_drain_state", {29'd0, bus.o_state}, 32'd0);
        check("rst_drain_halted", {31'd0, bus.o_halted}, 32'd0);
        check("rst_drain_cycle", bus.o_cycle_cnt, 32'd0);

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            rst               = ($urandom_range(0, 149) == 0);
            bus.i_start       = ($urandom_range(0, 7) == 0);
            bus.i_mode        = 1'($urandom_range(0, 1));
            bus.i_step        = 1'($urandom_range(0, 1));
            bus.i_clear       = ($urandom_range(0, 9) == 0);
            bus.i_id_rs_addr  = 5'($urandom_range(0, 3));
            bus.i_id_rt_addr  = 5'($urandom_range(0, 3));
            bus.i_id_uses_rt  = 1'($urandom_range(0, 1));
            bus.i_ex_rt_addr  = 5'($urandom_range(0, 3));
            bus.i_ex_mem_read = 1'($urandom_range(0, 1));
            bus.i_ex_taken    = ($urandom_range(0, 5) == 0);
            bus.i_ex_halt     = ($urandom_range(0, 24) == 0);
            tick();
        end
        rst = 0;
        clr_in();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
